// File: rtl/factorial_unit_if.sv
// factorial_unit_if: go/done request and result bundle for the factorial engine
interface factorial_unit_if #(
  parameter int IWIDE = 4,
  parameter int OWIDE = 32
);
  logic             go;
  logic             mode;
  logic [IWIDE-1:0] in;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [OWIDE-1:0] out;
  modport master (output go, mode, in, input busy, done, ovf, out);
  modport slave  (input go, mode, in, output busy, done, ovf, out);
endinterface

// File: rtl/factorial_unit.sv
// factorial_unit: iterative n! / n!! engine, one multiply per clock, saturating on overflow
module factorial_unit #(
  parameter int IWIDE = 4,
  parameter int OWIDE = 32
) (
  input logic             Clk,
  input logic             Rst,
  factorial_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [IWIDE-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic [OWIDE-1:0] prod_q, prod_d;
  logic [OWIDE-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic [OWIDE+IWIDE-1:0] p;
  assign p = {{IWIDE{1'b0}}, prod_q} * {{OWIDE{1'b0}}, cnt_q};
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.out  = out_q;
  assign bus.ovf  = ovf_q;
  // next state: accept in IDLE, multiply-and-count-down in RUN, any high product bit saturates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    prod_d  = prod_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (bus.go) begin
        state_d = RUN;
        cnt_d   = bus.in;
        step_d  = bus.mode;
        prod_d  = OWIDE'(1);
        out_d   = '0;
        ovf_d   = 1'b0;
      end
      RUN: if (cnt_q <= IWIDE'(1)) begin
        out_d   = prod_q;
        state_d = DONE;
      end else if (|p[OWIDE+IWIDE-1:OWIDE]) begin
        ovf_d   = 1'b1;
        out_d   = '1;
        state_d = DONE;
      end else begin
        prod_d = p[OWIDE-1:0];
        cnt_d  = cnt_q - (step_q ? IWIDE'(2) : IWIDE'(1));
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; reset discards any computation in flight
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      prod_q  <= OWIDE'(1);
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      prod_q  <= prod_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_factorial_unit.sv
// tb_factorial_unit: random and directed requests checked against a behavioural factorial model
module tb_factorial_unit;
  logic Clk, Rst;
  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;
  typedef struct packed {logic ovf; logic [31:0] res; logic [7:0] len;} exp_t;
  factorial_unit_if #(.IWIDE(4), .OWIDE(32)) bus ();
  factorial_unit #(.IWIDE(4), .OWIDE(32)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  initial Clk = 0;
  always #5 Clk = ~Clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
  endtask
  // result, overflow flag and RUN length straight from the arithmetic definition
  function automatic exp_t exp_calc(input int n, input bit md);
    longint r = 1;
    int k = 0;
    exp_t e;
    for (int i = n; i >= 2; i -= (md ? 2 : 1)) begin
      r *= i;
      k++;
      if (r > 64'hFFFFFFFF) begin
        e.ovf = 1'b1; e.res = '1; e.len = 8'(k);
        return e;
      end
    end
    e.ovf = 1'b0; e.res = 32'(r); e.len = 8'(k + 1);
    return e;
  endfunction
  int   m_ph = 0;
  int   m_left = 0;
  exp_t m_pend;
  logic [31:0] e_out = 0;
  logic e_ovf = 0;
  always @(posedge Clk) begin
    if (Rst) begin
      m_ph <= 0; m_left <= 0; e_out <= 0; e_ovf <= 0;
    end else if (m_ph == 0) begin
      if (bus.go) begin
        m_pend <= exp_calc(int'(bus.in), bus.mode);
        m_left <= int'(exp_calc(int'(bus.in), bus.mode).len);
        m_ph <= 1; e_out <= 0; e_ovf <= 0;
      end
    end else if (m_ph == 1) begin
      if (m_left == 1) begin
        m_ph <= 2; e_out <= m_pend.res; e_ovf <= m_pend.ovf;
      end else m_left <= m_left - 1;
    end else m_ph <= 0;
  end
  always @(negedge Clk) if (chk_en) begin
    chk("busy", 64'(bus.busy), 64'(m_ph == 1));
    chk("done", 64'(bus.done), 64'(m_ph == 2));
    chk("out", 64'(bus.out), 64'(e_out));
    chk("ovf", 64'(bus.ovf), 64'(e_ovf));
  end
  task automatic run_req(input int n, input bit md, input bit noise,
                         output logic [31:0] o, output logic ov, output int bc);
    bit seen = 0;
    bc = 0;
    @(negedge Clk);
    bus.go = 1; bus.in = 4'(n); bus.mode = md;
    @(negedge Clk);
    bus.go = 0; bus.in = 4'($urandom); bus.mode = 1'($urandom);
    for (int i = 0; i < 60; i++) begin
      if (bus.done) begin
        bus.go = 0; seen = 1;
        break;
      end
      if (bus.busy) bc++;
      bus.go = noise & 1'($urandom_range(0, 1));
      if (noise) bus.in = 4'(9);
      @(negedge Clk);
    end
    chk("done_seen", 64'(seen), 64'd1);
    o = bus.out; ov = bus.ovf;
  endtask
  task automatic directed(input string nm, input int n, input bit md,
                          input logic [31:0] r_out, input logic r_ovf, input int r_bc);
    logic [31:0] o; logic ov; int bc;
    run_req(n, md, 0, o, ov, bc);
    chk({nm, "_out"}, 64'(o), 64'(r_out));
    chk({nm, "_ovf"}, 64'(ov), 64'(r_ovf));
    if (r_bc > 0) chk({nm, "_busy_cycles"}, 64'(bc), 64'(r_bc));
  endtask
  initial begin
    exp_t e;
    logic [31:0] o; logic ov; int bc;
    int last_done, cyc, nd;
    e = exp_calc(5, 0);   chk("model_f5", 64'(e), 64'({1'b0, 32'd120, 8'd5}));
    e = exp_calc(12, 0);  chk("model_f12", 64'(e.res), 64'd479001600);
    e = exp_calc(7, 1);   chk("model_df7", 64'(e), 64'({1'b0, 32'd105, 8'd4}));
    e = exp_calc(15, 1);  chk("model_df15", 64'(e.res), 64'd2027025);
    e = exp_calc(13, 0);  chk("model_f13", 64'(e), 64'({1'b1, 32'hFFFFFFFF, 8'd12}));
    e = exp_calc(0, 1);   chk("model_df0", 64'(e), 64'({1'b0, 32'd1, 8'd1}));
    Rst = 1; bus.go = 0; bus.in = 0; bus.mode = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_out", 64'(bus.out), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    Rst = 0; chk_en = 1;
    repeat (10) @(negedge Clk);
    directed("f5", 5, 0, 120, 0, 5);
    directed("f12", 12, 0, 479001600, 0, 12);
    directed("f0", 0, 0, 1, 0, 1);
    directed("f1", 1, 0, 1, 0, 1);
    directed("df7", 7, 1, 105, 0, 4);
    directed("df8", 8, 1, 384, 0, 0);
    directed("df15", 15, 1, 2027025, 0, 0);
    directed("f13", 13, 0, 32'hFFFFFFFF, 1, 12);
    directed("f3", 3, 0, 6, 0, 0);
    run_req(4, 0, 1, o, ov, bc);
    chk("ignore_go_out", 64'(o), 64'd24);
    @(negedge Clk);
    bus.go = 1; bus.in = 3; bus.mode = 0;
    last_done = -1; nd = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge Clk);
      if (bus.done) begin
        if (last_done >= 0) chk("b2b_gap", 64'(cyc - last_done), 64'd5);
        last_done = cyc; nd++;
      end
    end
    chk("b2b_seen", 64'(nd >= 6), 64'd1);
    bus.go = 0;
    repeat (12) @(negedge Clk);
    @(negedge Clk);
    bus.go = 1; bus.in = 10; bus.mode = 0;
    @(negedge Clk);
    bus.go = 0;
    repeat (3) @(negedge Clk);
    Rst = 1;
    @(negedge Clk);
    Rst = 0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_out", 64'(bus.out), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    repeat (3) @(negedge Clk);
    directed("after_rst_f4", 4, 0, 24, 0, 4);
    for (int t = 0; t < 40; t++) begin
      int n; bit md;
      n = $urandom_range(0, 15); md = 1'($urandom_range(0, 1));
      e = exp_calc(n, md);
      run_req(n, md, 1'($urandom_range(0, 1)), o, ov, bc);
      chk("rnd_out", 64'(o), 64'(e.res));
      chk("rnd_ovf", 64'(ov), 64'(e.ovf));
      chk("rnd_busy_cycles", 64'(bc), 64'(e.len));
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end
    repeat (3) @(negedge Clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/factorial_unit.md
# factorial_unit

Parametrised iterative factorial engine, the next generation of the team's go/done factorial block. It computes n! or the double factorial n!! of an unsigned input with one multiply per clock. It adds a mode select, overflow detection with saturation, a busy flag, and a result/flag hold until the next accepted request. It sits as a multi-cycle co-processor beside the single-cycle datapath, which starts it with `go` and polls `busy`/`done`.

## Interface
- `IWIDE`, default 4: width of operand `in` and of the internal down-counter.
- `OWIDE`, default 32: width of result `out` and of the product register.
- `Clk`, input, 1: single clock; all state updates on the rising edge.
- `Rst`, input, 1: synchronous, active-high reset.
- `go`, input, 1: start request; sampled only in IDLE.
- `mode`, input, 1: 0 = n!, 1 = n!!; latched with `in` on accept.
- `in`, input, IWIDE: operand n, unsigned.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse, high only in DONE.
- `ovf`, output, 1: result exceeded OWIDE bits; held with `out`.
- `out`, output, OWIDE: result; held until the next accepted `go`.

## Operation
- States: IDLE, RUN, DONE. Outputs are Moore: `busy` = (state==RUN), `done` = (state==DONE).
- Reset (any state, including mid-RUN): state=IDLE, `out`=0, `ovf`=0, `busy`=0, `done`=0, product=1, counter=0. The in-flight computation is discarded.
- IDLE with `go`=1 at an edge:
  - latch cnt=`in`, step=`mode`?2:1;
  - prod=1, `ovf`=0, `out`=0;
  - go to RUN.
- IDLE with `go`=0: hold; `out`/`ovf` keep their last values.
- RUN edge with cnt<=1: `out`=prod, go to DONE.
- RUN edge with cnt>1:
  - full product p = prod*cnt, width OWIDE+IWIDE;
  - if p[OWIDE+IWIDE-1:OWIDE] != 0: `ovf`=1, `out`=all ones (saturate), go to DONE;
  - else prod=p[OWIDE-1:0], cnt=cnt-step.
- cnt never wraps. Subtraction happens only when cnt>=2, so the minimum cnt is 0.
- DONE: next edge always goes to IDLE.
- `go` is ignored in RUN and DONE. A `go` held high through DONE is accepted again on the first IDLE edge, which restarts the computation.
- 0! = 1! = 0!! = 1!! = 1.
- `in` and `mode` changes after accept have no effect.

## Timing
- Accept edge = the edge where IDLE samples `go`=1. `busy` is high from the cycle after the accept edge.
- Multiply count m:
  - n! : max(n-1, 0);
  - n!! : floor(n/2).
- RUN lasts m+1 cycles, or fewer if overflow terminates early (overflow at multiply k ends RUN after k cycles).
- `done` is high for exactly 1 cycle, immediately after the last RUN cycle.
- `out`/`ovf` are valid from the `done` cycle onward and are stable until the cycle after the next accept edge, when they clear to 0.
- Throughput: a new `go` can be accepted at the earliest 1 cycle after `done` (the IDLE cycle).
- Critical path: one OWIDE x IWIDE multiply plus the overflow OR-reduce; no pipelining.

## Test plan
- Reset/idle:
  - assert `Rst` for 2 cycles → `out`=0, `ovf`=0, `busy`=0, `done`=0;
  - `go`=0 for 10 cycles → all outputs stay unchanged.
- Factorial, IWIDE=4, OWIDE=32:
  - `in`=5, `mode`=0, pulse `go` → `busy` high 5 cycles, `done` 1 cycle, `out`=120, `ovf`=0;
  - `in`=12 → `out`=479001600;
  - `in`=0 and `in`=1 → `out`=1 with `busy` high 1 cycle.
- Double factorial:
  - `in`=7, `mode`=1 → `out`=105 after 4 RUN cycles;
  - `in`=8 → `out`=384;
  - `in`=15 → `out`=2027025, `ovf`=0.
- Overflow: `in`=13, `mode`=0 → `ovf`=1, `out`=32'hFFFFFFFF, `done` after 12 RUN cycles. The next request with `in`=3 → `ovf`=0, `out`=6.
- Handshake:
  - pulse `go` with `in`=9 mid-RUN of an `in`=4 request → ignored, `out`=24;
  - hold `go` high continuously → back-to-back results, each `done` separated by one IDLE cycle.
- Reset mid-operation: `in`=10, assert `Rst` in the 4th RUN cycle → next cycle state IDLE, `out`=0, `busy`=0, no `done` pulse. A following request with `in`=4 → `out`=24.
